// File: rtl/sync_debounce.sv
// sync_debounce: multi-channel input conditioner.
// Each channel is a STAGES-deep synchroniser followed by a debounce counter.
// A new level is accepted only after DEBOUNCE consecutive enabled cycles in
// which the synchronised input disagrees with the current output. A single
// cycle of agreement clears the count, so short glitches are rejected.
// Every accepted change produces a registered one-cycle rise or fall pulse.
// The changed output is the registered OR of all pulses.
// All outputs come straight from flops.
module sync_debounce #(
    parameter int               WIDTH     = 4,
    parameter int               STAGES    = 2,
    parameter int               DEBOUNCE  = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s_out;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] lvl_q, lvl_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    assign s_out = sync_q[STAGES-1];

    // Synchroniser chain: shifts every cycle, independent of en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= d_in;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-channel debounce decision: clear on agreement, count enabled
    // mismatches, and flip the level on the last required mismatch.
    always_comb begin
        lvl_d  = lvl_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s_out[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (en) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i]  = s_out[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s_out[i];
                    fall_d[i] = ~s_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    // Debounce state and registered pulse outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            lvl_q     <= RESET_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            lvl_q     <= lvl_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign q       = lvl_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Testbench for sync_debounce: directed scenarios plus a randomized run, all
// checked against a behavioural model that treats the synchroniser as a pure
// STAGES-edge delay and the debouncer as a count of enabled mismatch cycles.
module tb_sync_debounce;

    localparam int         WIDTH  = 4;
    localparam int         STAGES = 2;
    localparam int         DB     = 4;
    localparam logic [3:0] RV     = 4'b0101;

    logic             clk;
    logic             clk_run;
    logic             reset_n;
    logic             en;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] q, rise, fall;
    logic             changed;

    int n_cmp;
    int n_err;

    // model state
    logic [WIDTH-1:0] m_pipe[$];
    int               m_run[WIDTH];
    logic [WIDTH-1:0] m_q, m_rise, m_fall;
    logic             m_changed;

    sync_debounce #(
        .WIDTH(WIDTH), .STAGES(STAGES), .DEBOUNCE(DB), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .d_in(d_in),
        .q(q), .rise(rise), .fall(fall), .changed(changed)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1);
    end

    task automatic model_reset();
        m_pipe = {};
        for (int k = 0; k < STAGES; k++) m_pipe.push_back(RV);
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        m_q       = RV;
        m_rise    = '0;
        m_fall    = '0;
        m_changed = 1'b0;
    endtask

    // One rising edge of the model: the synchronised value seen at this edge
    // is the d_in sampled STAGES edges earlier.
    task automatic model_step();
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] nr, nf;
        s  = m_pipe[0];
        nr = '0;
        nf = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == m_q[i]) begin
                m_run[i] = 0;
            end else if (en) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_q[i]   = s[i];
                    m_run[i] = 0;
                    nr[i]    = s[i];
                    nf[i]    = ~s[i];
                end
            end
        end
        m_rise    = nr;
        m_fall    = nf;
        m_changed = |(nr | nf);
        void'(m_pipe.pop_front());
        m_pipe.push_back(d_in);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clk_run = 1'b1;
        reset_n = 1'b0;
        en      = 1'b1;
        d_in    = 4'b0000;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({q, rise, fall, changed} !== {RV, 4'b0, 4'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_initial: got q=%b r=%b f=%b c=%b, want q=%b r=0000 f=0000 c=0", q, rise, fall, changed, RV);
        end
        reset_n = 1'b1;
        d_in    = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            step();
            n_cmp++;
            if ({q, rise, fall, changed} !== {m_q, m_rise, m_fall, m_changed}) begin
                n_err++;
                $display("FAIL reset_preload k=%0d: got q=%b r=%b f=%b c=%b, want q=%b r=%b f=%b c=%b", k, q, rise, fall, changed, m_q, m_rise, m_fall, m_changed);
            end
        end
        n_cmp++;
        if (q !== 4'b1010) begin
            n_err++;
            $display("FAIL reset_preload_level: got q=%b, want q=1010", q);
        end
        // stop the clock low, then reset asynchronously
        clk_run = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({q, rise, fall, changed} !== {RV, 4'b0, 4'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_async: got q=%b r=%b f=%b c=%b, want q=%b r=0000 f=0000 c=0", q, rise, fall, changed, RV);
        end
        #10;
        d_in    = RV;
        clk_run = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_cmp++;
            if ({q, rise, fall, changed} !== {RV, 4'b0, 4'b0, 1'b0}) begin
                n_err++;
                $display("FAIL reset_quiet k=%0d: got q=%b r=%b f=%b c=%b, want q=%b r=0000 f=0000 c=0", k, q, rise, fall, changed, RV);
            end
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] eq, er, ef;
        d_in = 4'b0111;
        for (int k = 0; k < 8; k++) begin
            step();
            eq = (k >= 5) ? 4'b0111 : 4'b0101;
            er = (k == 5) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if ({q, rise, fall, changed} !== {eq, er, 4'b0000, (k == 5)}) begin
                n_err++;
                $display("FAIL basic_rise k=%0d: got q=%b r=%b f=%b c=%b, want q=%b r=%b f=0000 c=%0d", k, q, rise, fall, changed, eq, er, (k == 5));
            end
        end
        d_in = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            step();
            eq = (k >= 5) ? 4'b0101 : 4'b0111;
            ef = (k == 5) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if ({q, rise, fall, changed} !== {eq, 4'b0000, ef, (k == 5)}) begin
                n_err++;
                $display("FAIL basic_fall k=%0d: got q=%b r=%b f=%b c=%b, want q=%b r=0000 f=%b c=%0d", k, q, rise, fall, changed, eq, ef, (k == 5));
            end
        end
    endtask

    task automatic test_glitch();
        logic eq2;
        // low glitch of 3 cycles on channel 2 (currently high) is rejected
        d_in = 4'b0001;
        for (int k = 0; k < 13; k++) begin
            if (k == 3) d_in = 4'b0101;
            step();
            n_cmp++;
            if ({q, rise, fall, changed} !== {4'b0101, 4'b0, 4'b0, 1'b0}) begin
                n_err++;
                $display("FAIL glitch_reject k=%0d: got q=%b r=%b f=%b c=%b, want q=0101 r=0000 f=0000 c=0", k, q, rise, fall, changed);
            end
        end
        // 5-cycle low is accepted, then the return high is accepted too
        for (int k = 0; k < 15; k++) begin
            d_in = (k < 5) ? 4'b0001 : 4'b0101;
            step();
            eq2 = !(k >= 5 && k < 10);
            n_cmp++;
            if ({q[2], fall[2], rise[2]} !== {eq2, (k == 5), (k == 10)}) begin
                n_err++;
                $display("FAIL glitch_accept k=%0d: got q2=%b f2=%b r2=%b, want q2=%b f2=%0d r2=%0d", k, q[2], fall[2], rise[2], eq2, (k == 5), (k == 10));
            end
            n_cmp++;
            if ({q, rise, fall, changed} !== {m_q, m_rise, m_fall, m_changed}) begin
                n_err++;
                $display("FAIL glitch_model k=%0d: got q=%b r=%b f=%b c=%b, want q=%b r=%b f=%b c=%b", k, q, rise, fall, changed, m_q, m_rise, m_fall, m_changed);
            end
        end
    endtask

    task automatic test_enable();
        logic [5:0] en_seq;
        en_seq = 6'b110101;  // applied LSB first: 1,0,1,0,1,1
        en   = 1'b0;
        d_in = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            step();
            n_cmp++;
            if ({q, rise, fall, changed} !== {4'b0101, 4'b0, 4'b0, 1'b0}) begin
                n_err++;
                $display("FAIL enable_hold k=%0d: got q=%b r=%b f=%b c=%b, want q=0101 r=0000 f=0000 c=0", k, q, rise, fall, changed);
            end
        end
        for (int k = 0; k < 6; k++) begin
            en = en_seq[k];
            step();
            n_cmp++;
            if ({q[3], rise[3], changed} !== {(k == 5), (k == 5), (k == 5)}) begin
                n_err++;
                $display("FAIL enable_gate k=%0d: got q3=%b r3=%b c=%b, want q3=%0d r3=%0d c=%0d", k, q[3], rise[3], changed, (k == 5), (k == 5), (k == 5));
            end
        end
        en = 1'b1;
    endtask

    task automatic test_simultaneous();
        int pulses;
        d_in = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            step();
            n_cmp++;
            if ({q, rise, fall, changed} !== {m_q, m_rise, m_fall, m_changed}) begin
                n_err++;
                $display("FAIL simul_settle k=%0d: got q=%b r=%b f=%b c=%b, want q=%b r=%b f=%b c=%b", k, q, rise, fall, changed, m_q, m_rise, m_fall, m_changed);
            end
        end
        n_cmp++;
        if (q !== 4'b0000) begin
            n_err++;
            $display("FAIL simul_clear: got q=%b, want q=0000", q);
        end
        pulses = 0;
        d_in = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            step();
            if (changed === 1'b1) pulses++;
            n_cmp++;
            if ({rise, fall} !== {((k == 5) ? 4'b1010 : 4'b0000), 4'b0000}) begin
                n_err++;
                $display("FAIL simul_rise k=%0d: got r=%b f=%b, want r=%b f=0000", k, rise, fall, (k == 5) ? 4'b1010 : 4'b0000);
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL simul_changed_count: got %0d pulses, want 1", pulses);
        end
        d_in = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            n_cmp++;
            if ({rise, fall, changed} !== {4'b0000, ((k == 5) ? 4'b1010 : 4'b0000), (k == 5)}) begin
                n_err++;
                $display("FAIL simul_fall k=%0d: got r=%b f=%b c=%b, want r=0000 f=%b c=%0d", k, rise, fall, changed, (k == 5) ? 4'b1010 : 4'b0000, (k == 5));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] eq, er, ef;
        d_in = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if ({q, rise, fall, changed} !== {4'b0000, 4'b0, 4'b0, 1'b0}) begin
                n_err++;
                $display("FAIL rstmid_pending k=%0d: got q=%b r=%b f=%b c=%b, want q=0000 r=0000 f=0000 c=0", k, q, rise, fall, changed);
            end
        end
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({q, rise, fall, changed} !== {RV, 4'b0, 4'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid_async: got q=%b r=%b f=%b c=%b, want q=%b r=0000 f=0000 c=0", q, rise, fall, changed, RV);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            eq = (k >= 5) ? 4'b0010 : RV;
            er = (k == 5) ? 4'b0010 : 4'b0000;
            ef = (k == 5) ? 4'b0101 : 4'b0000;
            n_cmp++;
            if ({q, rise, fall, changed} !== {eq, er, ef, (k == 5)}) begin
                n_err++;
                $display("FAIL rstmid_relatch k=%0d: got q=%b r=%b f=%b c=%b, want q=%b r=%b f=%b c=%0d", k, q, rise, fall, changed, eq, er, ef, (k == 5));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if ($urandom_range(0, 7) == 0) d_in[i] = ~d_in[i];
            end
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                model_reset();
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                step();
            end
            n_cmp++;
            if ({q, rise, fall, changed} !== {m_q, m_rise, m_fall, m_changed}) begin
                n_err++;
                $display("FAIL random k=%0d: got q=%b r=%b f=%b c=%b, want q=%b r=%b f=%b c=%b", k, q, rise, fall, changed, m_q, m_rise, m_fall, m_changed);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        clk_run = 1'b0;
        reset_n = 1'b0;
        en      = 1'b1;
        d_in    = '0;
        test_reset();
        test_basic();
        test_glitch();
        test_enable();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Parametrised multi-channel input conditioner, successor to the single-bit synchronous flip-flop. Each channel passes an asynchronous input through a STAGES-deep synchroniser chain. A debounce counter follows, so the output level changes only after DEBOUNCE consecutive enabled cycles of disagreement. Registered one-cycle rise/fall pulses accompany each level change. The block sits between off-chip or cross-domain inputs (buttons, status lines) and the core logic.

## Interface
- WIDTH, 4: number of independent channels (≥1).
- STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE, 4: consecutive enabled mismatch cycles required to accept a new level (≥1).
- RESET_VAL, '0: WIDTH-bit value loaded into synchroniser flops and q on reset.

- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  debounce count enable (sample tick); synchroniser runs regardless.
- d_in  input  WIDTH  raw asynchronous inputs.
- q  output  WIDTH  debounced, synchronised level.
- rise  output  WIDTH  one-cycle pulse, bit i high in the cycle q[i] went 0→1.
- fall  output  WIDTH  one-cycle pulse, bit i high in the cycle q[i] went 1→0.
- changed  output  1  registered OR-reduction of (rise | fall), same cycle as the pulses.

## Operation
- Reset (reset_n low, asynchronous, takes effect without clk):
  - all synchroniser flops = RESET_VAL;
  - q = RESET_VAL;
  - all counters = 0;
  - rise = fall = 0, changed = 0.
- Synchroniser per channel i: s[0] <= d_in[i]; s[k] <= s[k-1]; s_out = s[STAGES-1]. Shifts every cycle, independent of en.
- Counter per channel: cnt, width $clog2(DEBOUNCE+1), unsigned, never exceeds DEBOUNCE-1.
- Per channel, each rising edge:
  - s_out == q[i]: cnt <= 0; q holds; no pulse.
  - s_out != q[i] and en == 0: cnt holds; q holds; no pulse.
  - s_out != q[i], en == 1, cnt < DEBOUNCE-1: cnt <= cnt+1.
  - s_out != q[i], en == 1, cnt == DEBOUNCE-1:
    - q[i] <= s_out; cnt <= 0;
    - rise[i] <= s_out; fall[i] <= ~s_out.
- Channel states, implicit: STABLE (cnt=0, agree) → PENDING (mismatch, counting) → STABLE with a level flip.
  - Any single cycle of agreement in PENDING returns to STABLE with cnt=0, no output change (glitch rejection).
- rise/fall are 0 in every cycle with no accepted change; they are never high for two consecutive cycles on the same channel.
- Channels are fully independent; simultaneous changes on several channels each produce their own pulse in the same cycle.
- changed <= |(next rise | next fall), registered alongside the pulses.

## Timing
- Conditions for minimum latency: d_in[i] changes and stays stable, en held high, and the first edge sampling the new value is E0.
  - s_out reflects the new value after edge E0+STAGES-1.
  - q[i], rise/fall and changed update at edge E0+STAGES+DEBOUNCE-1.
  - Total latency is STAGES+DEBOUNCE edges; defaults give 6.
- DEBOUNCE=1: q follows s_out one edge later (pure synchroniser plus edge detect).
- With en gated, the latency extends by the number of mismatch cycles with en=0; the count is preserved across those cycles.
- Reset asserted mid-count:
  - counters are cleared and q returns to RESET_VAL immediately;
  - any pending pulse is lost;
  - after deassertion, channels whose d_in differs from RESET_VAL start a fresh full-latency acceptance.
- Pulse width is exactly one clk cycle. Outputs are glitch-free (all registered).

## Test plan
- Reset: drive reset_n=0 mid-cycle with clk stopped, RESET_VAL=4'b0101 → q=0101, rise=fall=0, changed=0 asynchronously; hold d_in=0101 after release → no pulses for 20 cycles.
- Basic acceptance: defaults, en=1, d_in[0] 0→1 before edge E0 → q[0]=1, rise[0]=1 and changed=1 at edge E0+5 only; rise[0]=0 at E0+6; fall stays 0.
- Glitch rejection: d_in[2] high for 3 cycles then low, DEBOUNCE=4 → q[2] never changes, no pulses; d_in[2] high for 5 cycles → q[2] rises at the 6th edge after the first high sample.
- Enable gating: mismatch present, en toggling 1,0,1,0,1,1 → q changes only on the edge of the 4th en=1 cycle; cnt holds during en=0.
- Simultaneous channels: d_in 0000→1010 with q=0000, then 1010→0000 after settling → rise=1010 with one changed pulse; later fall=1010 with rise=0000.
- Reset mid-operation: assert reset_n after 2 counted cycles of a pending change on channel 1, release, hold d_in → q[1] changes a full STAGES+DEBOUNCE edges after release, with no early pulse.
